// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - VGA raster timing generator with pixel-clock prescaler
// Requests pixel (x,y) on pix_x/pix_y and drives its sync/colour one pixel period later.
module vga_timing_gen #(
  parameter int H_DISPLAY   = 640,
  parameter int H_FPORCH    = 16,
  parameter int H_SYNCPULSE = 96,
  parameter int H_BPORCH    = 48,
  parameter int V_DISPLAY   = 480,
  parameter int V_FPORCH    = 10,
  parameter int V_SYNCPULSE = 2,
  parameter int V_BPORCH    = 33,
  parameter int HSYNC_POL   = 0,
  parameter int VSYNC_POL   = 0,
  parameter int CLK_DIV     = 2,
  parameter int COLOR_W     = 1,
  localparam int H_TOTAL    = H_DISPLAY + H_FPORCH + H_SYNCPULSE + H_BPORCH,
  localparam int V_TOTAL    = V_DISPLAY + V_FPORCH + V_SYNCPULSE + V_BPORCH,
  localparam int XW         = $clog2(H_TOTAL),
  localparam int YW         = $clog2(V_TOTAL)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [COLOR_W-1:0] r_in,
  input  logic [COLOR_W-1:0] g_in,
  input  logic [COLOR_W-1:0] b_in,
  output logic [XW-1:0]      pix_x,
  output logic [YW-1:0]      pix_y,
  output logic               pix_tick,
  output logic               line_start,
  output logic               frame_start,
  output logic               hsync,
  output logic               vsync,
  output logic [COLOR_W-1:0] r,
  output logic [COLOR_W-1:0] g,
  output logic [COLOR_W-1:0] b,
  output logic               active
);

  if (H_FPORCH < 1 || H_SYNCPULSE < 1 || H_BPORCH < 1 ||
      V_FPORCH < 1 || V_SYNCPULSE < 1 || V_BPORCH < 1 || CLK_DIV < 1) begin : g_bad_params
    $error("vga_timing_gen: porch and pulse widths must be >= 1 and CLK_DIV >= 1");
  end

  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] P_LAST    = PW'(CLK_DIV - 1);
  localparam logic [XW-1:0] H_LAST    = XW'(H_TOTAL - 1);
  localparam logic [YW-1:0] V_LAST    = YW'(V_TOTAL - 1);
  localparam logic [XW-1:0] H_ACT_END = XW'(H_DISPLAY);
  localparam logic [YW-1:0] V_ACT_END = YW'(V_DISPLAY);
  localparam logic [XW-1:0] H_SYNC_LO = XW'(H_DISPLAY + H_FPORCH);
  localparam logic [XW-1:0] H_SYNC_HI = XW'(H_DISPLAY + H_FPORCH + H_SYNCPULSE - 1);
  localparam logic [YW-1:0] V_SYNC_LO = YW'(V_DISPLAY + V_FPORCH);
  localparam logic [YW-1:0] V_SYNC_HI = YW'(V_DISPLAY + V_FPORCH + V_SYNCPULSE - 1);
  localparam logic          HS_ACT    = (HSYNC_POL != 0);
  localparam logic          VS_ACT    = (VSYNC_POL != 0);

  logic [PW-1:0]      presc_q, presc_d;
  logic [XW-1:0]      h_cnt_q, h_cnt_d;
  logic [YW-1:0]      v_cnt_q, v_cnt_d;
  logic               hsync_q, hsync_d;
  logic               vsync_q, vsync_d;
  logic               active_q, active_d;
  logic [COLOR_W-1:0] r_q, r_d, g_q, g_d, b_q, b_d;
  logic               tick;
  logic               de;
  logic               in_hsync;
  logic               in_vsync;

  // Reset gates the tick so no strobe escapes while the counters are being cleared.
  assign tick     = en && !rst && (presc_q == P_LAST);
  assign de       = (h_cnt_q < H_ACT_END) && (v_cnt_q < V_ACT_END);
  assign in_hsync = (h_cnt_q >= H_SYNC_LO) && (h_cnt_q <= H_SYNC_HI);
  assign in_vsync = (v_cnt_q >= V_SYNC_LO) && (v_cnt_q <= V_SYNC_HI);

  always_comb begin
    presc_d  = presc_q;
    h_cnt_d  = h_cnt_q;
    v_cnt_d  = v_cnt_q;
    hsync_d  = hsync_q;
    vsync_d  = vsync_q;
    active_d = active_q;
    r_d      = r_q;
    g_d      = g_q;
    b_d      = b_q;
    if (en) begin
      presc_d = tick ? '0 : presc_q + PW'(1);
    end
    if (tick) begin
      active_d = de;
      r_d      = de ? r_in : '0;
      g_d      = de ? g_in : '0;
      b_d      = de ? b_in : '0;
      hsync_d  = in_hsync ? HS_ACT : ~HS_ACT;
      vsync_d  = in_vsync ? VS_ACT : ~VS_ACT;
      if (h_cnt_q == H_LAST) begin
        h_cnt_d = '0;
        v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + YW'(1);
      end else begin
        h_cnt_d = h_cnt_q + XW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q  <= '0;
      h_cnt_q  <= '0;
      v_cnt_q  <= '0;
      hsync_q  <= ~HS_ACT;
      vsync_q  <= ~VS_ACT;
      active_q <= 1'b0;
      r_q      <= '0;
      g_q      <= '0;
      b_q      <= '0;
    end else begin
      presc_q  <= presc_d;
      h_cnt_q  <= h_cnt_d;
      v_cnt_q  <= v_cnt_d;
      hsync_q  <= hsync_d;
      vsync_q  <= vsync_d;
      active_q <= active_d;
      r_q      <= r_d;
      g_q      <= g_d;
      b_q      <= b_d;
    end
  end

  assign pix_x       = h_cnt_q;
  assign pix_y       = v_cnt_q;
  assign pix_tick    = tick;
  assign line_start  = tick && (h_cnt_q == '0);
  assign frame_start = tick && (h_cnt_q == '0) && (v_cnt_q == '0);
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign active      = active_q;
  assign r           = r_q;
  assign g           = g_q;
  assign b           = b_q;

endmodule
